// File: rtl/pll_ctrl_pkg.sv
// Shared types for the rPLL reconfiguration sequencer.
//   pll_state_t : sequencer states
//   div_sel_t   : {idsel, fbdsel, odsel} divider-select triplet
//   DIV_W       : width of each divider select
package pll_ctrl_pkg;

    localparam int unsigned DIV_W = 6;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_state_t;

    typedef struct packed {
        logic [DIV_W-1:0] idsel;
        logic [DIV_W-1:0] fbdsel;
        logic [DIV_W-1:0] odsel;
    } div_sel_t;

endpackage

// File: rtl/pll_reconfig_ctrl_lock_filter.sv
// pll_lock_filter: 2-flop synchronizer for the asynchronous PLL LOCK plus a
// consecutive-high counter on the synchronized lock.
//   clk, rst     : crystal clock, synchronous active-high reset
//   pll_lock     : raw LOCK from the PLL (asynchronous)
//   count_en     : counting allowed (sequencer waiting for / qualifying lock)
//   lock_s       : synchronized lock
//   stable_done  : lock_s has been high for STABLE_CYCLES consecutive cycles
module pll_lock_filter #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    input  logic count_en,
    output logic lock_s,
    output logic stable_done
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pll_lock;
            sync2 <= sync1;
        end
    end

    assign lock_s = sync2;

    // Any low cycle restarts the run; the count saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || !count_en || !lock_s) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The current cycle is the STABLE_CYCLES-th consecutive high one.
    assign stable_done = count_en && lock_s && (cnt >= CNT_LAST);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: sequencer for the rPLL with dynamic dividers. Pulses the
// PLL RESET, drives IDSEL/FBDSEL/ODSEL, accepts new divider settings over a
// valid/ready handshake and holds user_rst until lock has been stable.
// Runs on the free-running crystal clock.
//   cfg_valid/cfg_ready, cfg_*sel : divider request (accepted in RUN or FAIL)
//   pll_lock                      : PLL LOCK (asynchronous)
//   pll_reset, pll_*sel           : registered PLL controls
//   user_rst                      : downstream reset, low only in RUN
//   locked / fail                 : high in RUN / FAIL
//   loss_cnt                      : saturating count of lock losses in RUN,
//                                   present only with `define PLL_LOSS_CNT_EN
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned      RST_CYCLES    = 16,
    parameter int unsigned      STABLE_CYCLES = 1024,
    parameter int unsigned      LOCK_TIMEOUT  = 65536,
    parameter int unsigned      MAX_RETRY     = 3,
    parameter logic [DIV_W-1:0] INIT_IDSEL    = 6'd0,
    parameter logic [DIV_W-1:0] INIT_FBDSEL   = 6'd3,
    parameter logic [DIV_W-1:0] INIT_ODSEL    = 6'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_idsel,
    input  logic [DIV_W-1:0] cfg_fbdsel,
    input  logic [DIV_W-1:0] cfg_odsel,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [DIV_W-1:0] pll_idsel,
    output logic [DIV_W-1:0] pll_fbdsel,
    output logic [DIV_W-1:0] pll_odsel,
    output logic             user_rst,
    output logic             locked,
`ifdef PLL_LOSS_CNT_EN
    output logic [7:0]       loss_cnt,
`endif
    output logic             fail
);

    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RT_W = $clog2(MAX_RETRY + 1);
    localparam logic [RC_W-1:0] RST_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(LOCK_TIMEOUT);
    localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);

    pll_state_t      state;
    pll_state_t      state_next;
    div_sel_t        sel_q;
    logic [RC_W-1:0] rst_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [RT_W-1:0] retry_cnt;
    logic            lock_s;
    logic            stable_done;
    logic            accept;
    logic            timeout;

    pll_lock_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lock_filter (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .count_en   ((state == WAIT_LOCK) || (state == STABLE)),
        .lock_s     (lock_s),
        .stable_done(stable_done)
    );

    assign cfg_ready = (state == RUN) || (state == FAIL);
    assign locked    = (state == RUN);
    assign fail      = (state == FAIL);
    assign accept    = cfg_valid && cfg_ready;
    assign timeout   = (to_cnt == TO_MAX);

    assign pll_idsel  = sel_q.idsel;
    assign pll_fbdsel = sel_q.fbdsel;
    assign pll_odsel  = sel_q.odsel;

    always_comb begin
        state_next = state;
        case (state)
            RESET_PLL: if (rst_cnt == RST_LAST) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = STABLE;
                end else if (timeout) begin
                    state_next = (retry_cnt == RETRY_MAX) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (stable_done) begin
                    state_next = RUN;
                end
            end
            // A config request takes priority over a simultaneous lock loss.
            RUN:     if (accept || !lock_s) state_next = RESET_PLL;
            FAIL:    if (accept) state_next = RESET_PLL;
            default: state_next = RESET_PLL;
        endcase
    end

    // pll_reset/user_rst are registered from the next state so they move on
    // the same edge as the state change; dividers are only loaded on an
    // accept, which always enters RESET_PLL on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_PLL;
            pll_reset <= 1'b1;
            user_rst  <= 1'b1;
            sel_q     <= '{idsel: INIT_IDSEL, fbdsel: INIT_FBDSEL, odsel: INIT_ODSEL};
            rst_cnt   <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_next;
            pll_reset <= (state_next == RESET_PLL) || (state_next == FAIL);
            user_rst  <= !((state == RUN) && (state_next == RUN));

            if (accept) begin
                sel_q <= '{idsel: cfg_idsel, fbdsel: cfg_fbdsel, odsel: cfg_odsel};
            end

            if ((state == RESET_PLL) && (state_next == RESET_PLL)) begin
                rst_cnt <= rst_cnt + 1'b1;
            end else begin
                rst_cnt <= '0;
            end

            // Held (not cleared) across STABLE so lock glitches cannot
            // postpone the timeout indefinitely.
            if ((state == RESET_PLL) || (state == RUN) || (state == FAIL)) begin
                to_cnt <= '0;
            end else if ((state == WAIT_LOCK) && !timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if ((state == STABLE && state_next == RUN) || (state == FAIL && accept)) begin
                retry_cnt <= '0;
            end else if (state == WAIT_LOCK && state_next == RESET_PLL) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

`ifdef PLL_LOSS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if ((state == RUN) && !lock_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with RST_CYCLES=4, STABLE_CYCLES=8,
// LOCK_TIMEOUT=32, MAX_RETRY=2. The bench plays the PLL: it drops LOCK while
// RESET is high and raises it a few cycles after RESET falls.
// Loss-counter checks are compiled in with `define PLL_LOSS_CNT_EN.
module tb_pll_reconfig_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       user_rst;
    logic       locked;
    logic       fail;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    pll_reconfig_ctrl #(
        .RST_CYCLES   (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (32),
        .MAX_RETRY    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idsel (cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel (cfg_odsel),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .user_rst  (user_rst),
        .locked    (locked),
`ifdef PLL_LOSS_CNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sels();
        return {14'd0, pll_idsel, pll_fbdsel, pll_odsel};
    endfunction

    function automatic logic [31:0] sel3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return {14'd0, a, b, c};
    endfunction

    // Negedges until pll_reset reads 0 (bounded).
    task automatic wait_reset_low(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pll_reset !== 1'b0 && n < 100);
    endtask

    task automatic wait_reset_high(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pll_reset !== 1'b1 && n < 100);
    endtask

    task automatic wait_user_low(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (user_rst !== 1'b0 && n < 200);
    endtask

    // From RESET_PLL with LOCK low: let the pulse end, lock 2 cycles later.
    task automatic relock(output bit ok);
        int a;
        int b;
        wait_reset_low(a);
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        wait_user_low(b);
        ok = (a == 4) && (b == 11);
    endtask

    initial begin
        int  n;
        int  falls;
        int  good;
        bit  ok;
        logic prev;

        rst        = 1'b1;
        pll_lock   = 1'b0;
        cfg_valid  = 1'b0;
        cfg_idsel  = '0;
        cfg_fbdsel = '0;
        cfg_odsel  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pll_reset", 32'(pll_reset), 1);
        check("rst_user_rst", 32'(user_rst), 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_sels", sels(), sel3(6'd0, 6'd3, 6'd2));
`ifdef PLL_LOSS_CNT_EN
        check("rst_loss_cnt", 32'(loss_cnt), 0);
`endif

        // Power-up
        rst = 1'b0;
        wait_reset_low(n);
        check("pwr_reset_len", 32'(n), 4);
        repeat (10) @(negedge clk);
        check("pwr_urst_waiting", 32'(user_rst), 1);
        pll_lock = 1'b1;
        wait_user_low(n);
        check("pwr_release", 32'(n), 11);
        check("pwr_locked", 32'(locked), 1);
        check("pwr_cfg_ready", 32'(cfg_ready), 1);
        check("pwr_sels", sels(), sel3(6'd0, 6'd3, 6'd2));

        // Reconfig in RUN
        cfg_idsel = 6'd1; cfg_fbdsel = 6'd7; cfg_odsel = 6'd4;
        cfg_valid = 1'b1;
        @(negedge clk);
        check("rcfg_pll_reset", 32'(pll_reset), 1);
        check("rcfg_user_rst", 32'(user_rst), 1);
        check("rcfg_sels", sels(), sel3(6'd1, 6'd7, 6'd4));
        check("rcfg_ready_drop", 32'(cfg_ready), 0);
        cfg_valid = 1'b0;
        pll_lock  = 1'b0;
        relock(ok);
        check("rcfg_relock", 32'(ok), 1);
        check("rcfg_sels_kept", sels(), sel3(6'd1, 6'd7, 6'd4));

        // Lock loss in RUN: seen after the 2-flop sync, user_rst the cycle after
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check("loss_urst_hold", 32'(user_rst), 0);
        @(negedge clk);
        check("loss_urst", 32'(user_rst), 1);
        check("loss_pll_reset", 32'(pll_reset), 1);
`ifdef PLL_LOSS_CNT_EN
        check("loss_cnt_1", 32'(loss_cnt), 1);
`endif
        check("loss_sels_kept", sels(), sel3(6'd1, 6'd7, 6'd4));

        // Lock glitch at stable count 5
        wait_reset_low(n);
        check("glitch_reset_len", 32'(n), 4);
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_user_low(n);
        check("glitch_release", 32'(n), 11);

        // Lock loss and cfg in the same cycle
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        cfg_idsel = 6'd9; cfg_fbdsel = 6'd12; cfg_odsel = 6'd33;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("both_sels", sels(), sel3(6'd9, 6'd12, 6'd33));
        check("both_pll_reset", 32'(pll_reset), 1);
        check("both_user_rst", 32'(user_rst), 1);
`ifdef PLL_LOSS_CNT_EN
        check("both_loss_cnt", 32'(loss_cnt), 2);
`endif
        relock(ok);
        check("both_relock", 32'(ok), 1);

        // 300 further losses: counter saturates at 255
        good = 0;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            wait_reset_high(n);
            relock(ok);
            if (ok && n == 3) good++;
`ifdef PLL_LOSS_CNT_EN
            if (i == 251) check("loss_cnt_254", 32'(loss_cnt), 254);
`endif
        end
        check("loss_loop_relocks", 32'(good), 300);
`ifdef PLL_LOSS_CNT_EN
        check("loss_cnt_sat", 32'(loss_cnt), 255);
`endif

        // Timeout: rst reload, cfg ignored outside RUN/FAIL, 3 pulses then FAIL
        rst      = 1'b1;
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_sels", sels(), sel3(6'd0, 6'd3, 6'd2));
`ifdef PLL_LOSS_CNT_EN
        check("rst2_loss_cnt", 32'(loss_cnt), 0);
`endif
        rst   = 1'b0;
        n     = 0;
        falls = 0;
        prev  = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
            if (n == 1) begin
                cfg_idsel = 6'd63; cfg_fbdsel = 6'd63; cfg_odsel = 6'd63;
                cfg_valid = 1'b1;
            end
            if (n == 3) begin
                check("ign_cfg_ready", 32'(cfg_ready), 0);
                cfg_valid = 1'b0;
            end
        end while (fail !== 1'b1 && n < 600);
        check("tmo_cycles", 32'(n), 111);
        check("tmo_pulses", 32'(falls), 3);
        check("tmo_pll_reset", 32'(pll_reset), 1);
        check("tmo_cfg_ready", 32'(cfg_ready), 1);
        check("tmo_user_rst", 32'(user_rst), 1);
        check("tmo_locked", 32'(locked), 0);
        check("ign_sels", sels(), sel3(6'd0, 6'd3, 6'd2));
        repeat (5) @(negedge clk);
        check("fail_sticky", 32'(fail), 1);

        // New cfg leaves FAIL
        cfg_idsel = 6'd2; cfg_fbdsel = 6'd5; cfg_odsel = 6'd3;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("fcfg_fail", 32'(fail), 0);
        check("fcfg_pll_reset", 32'(pll_reset), 1);
        check("fcfg_sels", sels(), sel3(6'd2, 6'd5, 6'd3));
        relock(ok);
        check("fcfg_relock", 32'(ok), 1);
        check("fcfg_locked", 32'(locked), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
